// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared state encoding and bus-width defaults for dmem_arbiter.
// Revision : 1.0
// ============================================================================
package dmem_arb_pkg;

    localparam int c_DEF_DATA_W     = 16;
    localparam int c_DEF_ADDR_W     = 16;
    localparam int c_DEF_STARVE_LIM = 4;

    typedef enum logic [1:0] {
        ST_CORE_PRI  = 2'd0,
        ST_DBG_FORCE = 2'd1,
        ST_DBG_LOCK  = 2'd2
    } arb_state_t;

    // Counter must be able to hold the value STARVE_LIM itself.
    function automatic int cnt_width(input int lim);
        return (lim < 1) ? 1 : $clog2(lim + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_wait_counter
// Brief    : Counts consecutive denied debug cycles; flags the starvation edge.
// Revision : 1.0
// ============================================================================
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIM = c_DEF_STARVE_LIM
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic last
);

    localparam int c_CNT_W = cnt_width(STARVE_LIM);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // One more denied cycle would reach the limit.
    assign last = (r_cnt == c_CNT_W'(STARVE_LIM - 1));

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Core/debug data-memory arbiter with starvation relief and debug
//            lock. Optional stall statistics via DMEM_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int STARVE_LIM = c_DEF_STARVE_LIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       w_core_grant;
    logic       w_dbg_grant;
    logic       w_cnt_inc;
    logic       w_cnt_clr;
    logic       w_cnt_last;

    arb_wait_counter #(
        .STARVE_LIM (STARVE_LIM)
    ) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_cnt_inc),
        .clr  (w_cnt_clr),
        .last (w_cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_CORE_PRI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are gated by rst so nothing is granted while reset is held.
    always_comb begin
        w_state_nxt  = r_state;
        w_core_grant = 1'b0;
        w_dbg_grant  = 1'b0;
        w_cnt_inc    = 1'b0;
        w_cnt_clr    = 1'b0;
        if (rst) begin
            case (r_state)
                ST_CORE_PRI: begin
                    if (core_req) begin
                        w_core_grant = 1'b1;
                    end else if (dbg_req) begin
                        w_dbg_grant = 1'b1;
                    end
                    if (dbg_req && !w_dbg_grant) begin
                        w_cnt_inc = 1'b1;
                    end else begin
                        w_cnt_clr = 1'b1;
                    end
                    // Lock request outranks the starvation slot.
                    if (dbg_req && dbg_lock) begin
                        w_state_nxt = ST_DBG_LOCK;
                        w_cnt_inc   = 1'b0;
                        w_cnt_clr   = 1'b1;
                    end else if (w_cnt_inc && w_cnt_last) begin
                        w_state_nxt = ST_DBG_FORCE;
                    end
                end
                ST_DBG_FORCE: begin
                    w_dbg_grant = dbg_req;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_CORE_PRI;
                end
                ST_DBG_LOCK: begin
                    w_dbg_grant = dbg_req;
                    w_cnt_clr   = 1'b1;
                    if (!dbg_lock) begin
                        w_state_nxt = ST_CORE_PRI;
                    end
                end
                default: begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_CORE_PRI;
                end
            endcase
        end
    end

    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        core_rdata      = '0;
        dbg_rdata       = '0;
        if (w_core_grant) begin
            mem_access_addr = core_addr;
            mem_write_data  = core_wdata;
            mem_write_en    = core_we;
            core_rdata      = mem_read_data;
        end else if (w_dbg_grant) begin
            mem_access_addr = dbg_addr;
            mem_write_data  = dbg_wdata;
            mem_write_en    = dbg_we;
            dbg_rdata       = mem_read_data;
        end
    end

    assign core_stall = rst && core_req && !w_core_grant;
    assign dbg_ack    = w_dbg_grant;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (core_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data bus width.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning data memory address width.
REQ-003 SHALL have parameter STARVE_LIM, default 4, meaning the number of consecutive denied debug-request cycles before a forced debug slot.
REQ-004 SHALL have ports as follows:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assertion, active-low.
- core_req  in  1  core requests a data memory access this cycle.
- core_we  in  1  core access is a write.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_rdata  out  DATA_W  read data to core.
- core_stall  out  1  core request not granted this cycle.
- dbg_req  in  1  debug/loader requests an access.
- dbg_we  in  1  debug access is a write.
- dbg_lock  in  1  debug requests exclusive ownership.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_rdata  out  DATA_W  read data to debug.
- dbg_ack  out  1  debug access granted this cycle.
- mem_access_addr  out  ADDR_W  data memory address.
- mem_write_data  out  DATA_W  data memory write data.
- mem_write_en  out  1  data memory write strobe.
- mem_read_data  in  DATA_W  data memory combinational read data.

Function
REQ-005 SHALL decide the grant combinationally each cycle from the requests, arb_state and wait_cnt; at most one requester is granted per cycle.
REQ-006 SHALL implement arb_state in {ST_CORE_PRI, ST_DBG_FORCE, ST_DBG_LOCK}.
REQ-007 In ST_CORE_PRI: grant core if core_req, else grant debug if dbg_req.
REQ-008 In ST_CORE_PRI, wait_cnt SHALL increment when dbg_req is set and debug is not granted, and clear when debug is granted or dbg_req is low.
REQ-009 In ST_CORE_PRI, the FSM SHALL go to ST_DBG_FORCE when an increment would make wait_cnt reach STARVE_LIM.
REQ-010 In ST_DBG_FORCE: grant debug if dbg_req, with core_stall=core_req; next state ST_CORE_PRI unconditionally; wait_cnt cleared.
REQ-011 dbg_lock&&dbg_req in ST_CORE_PRI SHALL move the FSM to ST_DBG_LOCK next cycle; the current cycle arbitrates normally.
REQ-012 In ST_DBG_LOCK: debug is granted whenever dbg_req; core is never granted; exit to ST_CORE_PRI when dbg_lock is low.
REQ-013 The granted requester's addr/wdata/we SHALL drive the mem_* outputs; with no grant, mem_access_addr=0, mem_write_data=0, mem_write_en=0.
REQ-014 Access latency SHALL be zero cycles: reads return mem_read_data the same cycle on core_rdata/dbg_rdata, and writes commit at the next rising edge.
REQ-015 core_stall SHALL equal core_req && !core_grant; dbg_ack SHALL equal dbg_grant.
REQ-016 Non-granted rdata outputs SHALL be 0.
REQ-017 Simultaneous requests to the same address SHALL apply only the granted access; no write merging.

Reset
REQ-018 While rst is low: arb_state=ST_CORE_PRI, wait_cnt=0, mem_write_en=0, dbg_ack=0, core_stall=0, all data outputs 0, regardless of requests.
REQ-019 Assertion of rst mid-lock or mid-force SHALL abandon the state; the first cycle after release behaves as ST_CORE_PRI.

Configuration
REQ-020 When DMEM_ARB_STATS_EN is defined, the block SHALL add output stall_cnt (16 bits), a saturating count of cycles with core_stall=1, cleared by rst.
REQ-021 When DMEM_ARB_STATS_EN is undefined, the block SHALL have neither the stall_cnt port nor the counter logic.

Structure
REQ-022 The state encoding and the ADDR_W/DATA_W defaults SHALL live in shared package dmem_arb_pkg.
REQ-023 The wait counter and its STARVE_LIM compare SHALL be sub-module arb_wait_counter; the FSM and mux SHALL stay in dmem_arbiter.

Verification
REQ-024 The bench SHALL cover each of the following directed scenarios:
- Core write addr 10 data 0x1234 with dbg_req low: mem_write_en=1 same cycle, ram[10]=0x1234 next cycle, core_stall=0.
- core_req and dbg_req held high continuously with STARVE_LIM=4: core granted 4 cycles, debug granted cycle 5 with core_stall=1, then the pattern repeats.
- dbg_lock=1 with dbg_req=1 and core_req=1: from the next cycle core_stall=1 every cycle; debug writes addrs 0..3 succeed; dropping dbg_lock gives core the grant the following cycle.
- Debug read addr 10 after the core write: dbg_rdata=0x1234 and dbg_ack=1 in the same cycle.
- rst pulled low during ST_DBG_LOCK with a pending write: mem_write_en=0 immediately, ram unchanged, and after release the core is granted first.
- With DMEM_ARB_STATS_EN defined, the starvation scenario run for 50 cycles gives stall_cnt=10.
